// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: clears a register file after reset, then runs
// one read/ALU/writeback command at a time against it.
module rf_op_sequencer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] rf_data_in,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_port1,
    input  logic [DATA_W-1:0] rf_read_port2,
    output logic              init_done,
    output logic              done_valid,
    output logic [DATA_W-1:0] done_result,
    output logic              done_carry
);

    localparam int CNT_W = $clog2(NUM_REGS + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_clr_cnt;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_dst;
    logic [DATA_W-1:0]   r_imm;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;
    logic [DATA_W:0]     r_res;
    logic                r_cmd_ready;
    logic [DATA_W-1:0]   r_data_in;
    logic [ADDR_W-1:0]   r_write_addr;
    logic                r_write_en;
    logic [ADDR_W-1:0]   r_read_addr1;
    logic [ADDR_W-1:0]   r_read_addr2;
    logic                r_init_done;
    logic                r_done_valid;
    logic [DATA_W-1:0]   r_done_result;
    logic                r_done_carry;

    state_t              w_state;
    logic [CNT_W-1:0]    w_clr_cnt;
    logic [2:0]          w_op;
    logic [ADDR_W-1:0]   w_dst;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_opa;
    logic [DATA_W-1:0]   w_opb;
    logic [DATA_W:0]     w_res;
    logic                w_cmd_ready;
    logic [DATA_W-1:0]   w_data_in;
    logic [ADDR_W-1:0]   w_write_addr;
    logic                w_write_en;
    logic [ADDR_W-1:0]   w_read_addr1;
    logic [ADDR_W-1:0]   w_read_addr2;
    logic                w_init_done;
    logic                w_done_valid;
    logic [DATA_W-1:0]   w_done_result;
    logic                w_done_carry;
    logic [DATA_W:0]     w_alu;

    assign cmd_ready     = r_cmd_ready;
    assign rf_data_in    = r_data_in;
    assign rf_write_addr = r_write_addr;
    assign rf_write_en   = r_write_en;
    assign rf_read_addr1 = r_read_addr1;
    assign rf_read_addr2 = r_read_addr2;
    assign init_done     = r_init_done;
    assign done_valid    = r_done_valid;
    assign done_result   = r_done_result;
    assign done_carry    = r_done_carry;

    // 17-bit ALU; bit DATA_W carries carry/borrow
    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_ADD:  w_alu = {1'b0, r_opa} + {1'b0, r_opb};
            OP_SUB:  w_alu = {1'b0, r_opa} - {1'b0, r_opb};
            OP_AND:  w_alu = {1'b0, r_opa & r_opb};
            OP_OR:   w_alu = {1'b0, r_opa | r_opb};
            OP_XOR:  w_alu = {1'b0, r_opa ^ r_opb};
            OP_LDI:  w_alu = {1'b0, r_imm};
            OP_SHL:  w_alu = {r_opa, 1'b0};
            OP_CMP:  w_alu = {1'b0, r_opa} - {1'b0, r_opb};
            default: w_alu = '0;
        endcase
    end

    // next-state and next registered outputs
    always_comb begin
        w_state       = r_state;
        w_clr_cnt     = r_clr_cnt;
        w_op          = r_op;
        w_dst         = r_dst;
        w_imm         = r_imm;
        w_opa         = r_opa;
        w_opb         = r_opb;
        w_res         = r_res;
        w_cmd_ready   = 1'b0;
        w_data_in     = r_data_in;
        w_write_addr  = r_write_addr;
        w_write_en    = 1'b0;
        w_read_addr1  = r_read_addr1;
        w_read_addr2  = r_read_addr2;
        w_init_done   = r_init_done;
        w_done_valid  = 1'b0;
        w_done_result = r_done_result;
        w_done_carry  = r_done_carry;
        unique case (r_state)
            S_CLEAR: begin
                if (r_clr_cnt == CNT_W'(NUM_REGS)) begin
                    w_init_done = 1'b1;
                    w_cmd_ready = 1'b1;
                    w_state     = S_IDLE;
                end else begin
                    w_write_en   = 1'b1;
                    w_write_addr = r_clr_cnt[ADDR_W-1:0];
                    w_data_in    = '0;
                    w_clr_cnt    = r_clr_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_op         = cmd_op;
                    w_dst        = cmd_dst;
                    w_imm        = cmd_imm;
                    w_read_addr1 = cmd_src1;
                    w_read_addr2 = cmd_src2;
                    w_cmd_ready  = 1'b0;
                    w_state      = S_READ;
                end
            end
            S_READ: begin
                w_opa   = rf_read_port1;
                w_opb   = rf_read_port2;
                w_state = S_EXEC;
            end
            S_EXEC: begin
                w_res        = w_alu;
                w_write_en   = (r_op != OP_CMP);
                w_write_addr = r_dst;
                w_data_in    = w_alu[DATA_W-1:0];
                w_state      = S_WRITE;
            end
            S_WRITE: begin
                w_done_valid  = 1'b1;
                w_done_result = r_res[DATA_W-1:0];
                w_done_carry  = r_res[DATA_W];
                w_cmd_ready   = 1'b1;
                w_state       = S_IDLE;
            end
            default: w_state = S_CLEAR;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_CLEAR;
            r_clr_cnt     <= '0;
            r_op          <= '0;
            r_dst         <= '0;
            r_imm         <= '0;
            r_opa         <= '0;
            r_opb         <= '0;
            r_res         <= '0;
            r_cmd_ready   <= 1'b0;
            r_data_in     <= '0;
            r_write_addr  <= '0;
            r_write_en    <= 1'b0;
            r_read_addr1  <= '0;
            r_read_addr2  <= '0;
            r_init_done   <= 1'b0;
            r_done_valid  <= 1'b0;
            r_done_result <= '0;
            r_done_carry  <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_clr_cnt     <= w_clr_cnt;
            r_op          <= w_op;
            r_dst         <= w_dst;
            r_imm         <= w_imm;
            r_opa         <= w_opa;
            r_opb         <= w_opb;
            r_res         <= w_res;
            r_cmd_ready   <= w_cmd_ready;
            r_data_in     <= w_data_in;
            r_write_addr  <= w_write_addr;
            r_write_en    <= w_write_en;
            r_read_addr1  <= w_read_addr1;
            r_read_addr2  <= w_read_addr2;
            r_init_done   <= w_init_done;
            r_done_valid  <= w_done_valid;
            r_done_result <= w_done_result;
            r_done_carry  <= w_done_carry;
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// tb_rf_op_sequencer: directed commands against a bench register file,
// checked every cycle against an architectural command model.
module tb_rf_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_src1;
    logic [3:0]  cmd_src2;
    logic [3:0]  cmd_dst;
    logic [15:0] cmd_imm;
    logic [15:0] rf_data_in;
    logic [3:0]  rf_write_addr;
    logic        rf_write_en;
    logic [3:0]  rf_read_addr1;
    logic [3:0]  rf_read_addr2;
    logic [15:0] rf_read_port1;
    logic [15:0] rf_read_port2;
    logic        init_done;
    logic        done_valid;
    logic [15:0] done_result;
    logic        done_carry;

    rf_op_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_src1      (cmd_src1),
        .cmd_src2      (cmd_src2),
        .cmd_dst       (cmd_dst),
        .cmd_imm       (cmd_imm),
        .rf_data_in    (rf_data_in),
        .rf_write_addr (rf_write_addr),
        .rf_write_en   (rf_write_en),
        .rf_read_addr1 (rf_read_addr1),
        .rf_read_addr2 (rf_read_addr2),
        .rf_read_port1 (rf_read_port1),
        .rf_read_port2 (rf_read_port2),
        .init_done     (init_done),
        .done_valid    (done_valid),
        .done_result   (done_result),
        .done_carry    (done_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rf [16];
    initial for (int i = 0; i < 16; i++) rf[i] = 16'hAAAA;
    always @(posedge clk) if (rf_write_en) rf[rf_write_addr] <= rf_data_in;
    assign rf_read_port1 = rf[rf_read_addr1];
    assign rf_read_port2 = rf[rf_read_addr2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int  acc;
        bit  is_cmp;
        int  dst;
        int  s1;
        int  s2;
        int  res;
        int  carry;
    } exp_t;

    exp_t q[$];
    int   ref_rf [16];
    int   acc_log[$];
    int   cyc = 0;

    function automatic void model(input int op, input int a, input int b,
                                  input int imm, output int r, output int c);
        c = 0;
        case (op)
            0: begin r = a + b; c = (r > 65535); end
            1, 7: begin r = a - b; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = imm;
            6: begin r = a * 2; c = (a >= 32768); end
            default: r = 0;
        endcase
        r = r & 65535;
    endfunction

    // per-cycle comparison against the architectural model
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 16; i++) ref_rf[i] = 0;
        end else if (init_done) begin
            bit exp_we;
            bit exp_dv;
            exp_we = 0;
            exp_dv = 0;
            if (q.size() > 0) begin
                if (cyc == q[0].acc + 1) begin
                    chk("rd_addr1", rf_read_addr1, q[0].s1);
                    chk("rd_addr2", rf_read_addr2, q[0].s2);
                end
                if (cyc == q[0].acc + 3) exp_we = !q[0].is_cmp;
                if (cyc == q[0].acc + 4) exp_dv = 1;
            end
            chk("write_en", rf_write_en, exp_we);
            if (exp_we) begin
                chk("write_addr", rf_write_addr, q[0].dst);
                chk("write_data", rf_data_in, q[0].res);
            end
            chk("done_valid", done_valid, exp_dv);
            if (exp_dv) begin
                chk("done_result", done_result, q[0].res);
                chk("done_carry", done_carry, q[0].carry);
                chk("rf_dst", rf[q[0].dst], ref_rf[q[0].dst]);
                void'(q.pop_front());
            end
            chk("cmd_ready", cmd_ready, q.size() == 0);
            if (cmd_valid && cmd_ready) begin
                exp_t e;
                int r, c;
                model(cmd_op, ref_rf[cmd_src1], ref_rf[cmd_src2],
                      cmd_imm, r, c);
                e.acc = cyc;
                e.is_cmp = (cmd_op == 3'b111);
                e.dst = cmd_dst;
                e.s1 = cmd_src1;
                e.s2 = cmd_src2;
                e.res = r;
                e.carry = c;
                q.push_back(e);
                acc_log.push_back(cyc);
                if (!e.is_cmp) ref_rf[cmd_dst] = r;
            end
        end
    end

    task automatic send(input int op, input int s1, input int s2,
                        input int d, input int imm, input bit hold);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1;
        cmd_op = op[2:0];
        cmd_src1 = s1[3:0];
        cmd_src2 = s2[3:0];
        cmd_dst = d[3:0];
        cmd_imm = imm[15:0];
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic check_clear();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("clr_we", rf_write_en, 1);
            chk("clr_addr", rf_write_addr, i);
            chk("clr_data", rf_data_in, 0);
            chk("clr_ready", cmd_ready, 0);
            chk("clr_init", init_done, 0);
        end
        @(negedge clk);
        chk("post_clr_we", rf_write_en, 0);
        chk("post_clr_init", init_done, 1);
        chk("post_clr_ready", cmd_ready, 1);
        for (int i = 0; i < 16; i++) chk("clr_reg", rf[i], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 0;
        cmd_valid = 0;
        cmd_op = 0;
        cmd_src1 = 0;
        cmd_src2 = 0;
        cmd_dst = 0;
        cmd_imm = 0;
        repeat (3) @(negedge clk);
        chk("rst_we", rf_write_en, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_init", init_done, 0);
        chk("rst_dv", done_valid, 0);
        chk("rst_res", done_result, 0);
        rst_n = 1;
        check_clear();

        send(5, 0, 0, 4, 5560, 0);
        wait_idle();
        send(5, 0, 0, 12, 11324, 0);
        wait_idle();
        send(0, 4, 12, 9, 0, 0);
        wait_idle();
        chk("add_res", done_result, 16884);
        chk("add_carry", done_carry, 0);
        chk("add_r9", rf[9], 16884);
        n = acc_log.size();

        send(1, 4, 12, 7, 0, 0);
        wait_idle();
        chk("sub_res", done_result, 59772);
        chk("sub_carry", done_carry, 1);
        chk("sub_r7", rf[7], 59772);

        send(7, 4, 12, 4, 0, 0);
        wait_idle();
        chk("cmp_res", done_result, 59772);
        chk("cmp_carry", done_carry, 1);
        chk("cmp_r4", rf[4], 5560);

        send(5, 0, 0, 1, 16'hFFFF, 0);
        wait_idle();
        send(0, 1, 1, 2, 0, 0);
        wait_idle();
        chk("addc_res", done_result, 16'hFFFE);
        chk("addc_carry", done_carry, 1);
        send(6, 1, 1, 3, 0, 0);
        wait_idle();
        chk("shl_res", done_result, 16'hFFFE);
        chk("shl_carry", done_carry, 1);
        chk("shl_r3", rf[3], 16'hFFFE);

        n = acc_log.size();
        send(5, 0, 0, 6, 100, 1);
        send(0, 6, 6, 7, 0, 1);
        send(4, 7, 6, 8, 0, 0);
        wait_idle();
        chk("b2b_count", acc_log.size() - n, 3);
        if (acc_log.size() - n == 3) begin
            chk("b2b_gap1", acc_log[n+1] - acc_log[n], 4);
            chk("b2b_gap2", acc_log[n+2] - acc_log[n+1], 4);
        end
        chk("b2b_res", done_result, 172);
        chk("b2b_r7", rf[7], 200);
        chk("b2b_r8", rf[8], 172);

        send(0, 4, 12, 5, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("midrst_we", rf_write_en, 0);
        chk("midrst_ready", cmd_ready, 0);
        chk("midrst_init", init_done, 0);
        repeat (4) begin
            @(negedge clk);
            chk("midrst_dv", done_valid, 0);
            chk("midrst_we2", rf_write_en, 0);
            chk("midrst_r5", rf[5], 0);
        end
        rst_n = 1;
        check_clear();

        send(5, 0, 0, 10, 16'h1234, 0);
        wait_idle();
        chk("final_res", done_result, 16'h1234);
        chk("final_r10", rf[10], 16'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
